// File: rtl/icache_unit_param.sv
// Set-associative instruction cache with per-set age LRU, bus miss handling,
// snoop invalidation and a saturating miss counter.
module icache_unit_param #(
    parameter int ADDR_W = 32,
    parameter int SETS   = 4,
    parameter int ASSOC  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PrRd,
    input  logic [ADDR_W-1:0] Address,
    output logic [ADDR_W-1:0] Data_Bus,
    output logic              CPU_stall,
    output logic              Com_Bus_Req_proc,
    input  logic              Com_Bus_Gnt_proc,
    output logic [ADDR_W-1:0] Address_Com,
    input  logic [ADDR_W-1:0] Data_Bus_Com,
    input  logic              Data_in_Bus,
    input  logic              Inv_Valid,
    input  logic [ADDR_W-1:0] Inv_Address,
    output logic [15:0]       Miss_Count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int AGE_W = $clog2(ASSOC);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

    state_t            state_q, state_d;
    logic [TAG_W-1:0]  tag_q   [SETS][ASSOC];
    logic [TAG_W-1:0]  tag_d   [SETS][ASSOC];
    logic              valid_q [SETS][ASSOC];
    logic              valid_d [SETS][ASSOC];
    logic [ADDR_W-1:0] data_q  [SETS][ASSOC];
    logic [ADDR_W-1:0] data_d  [SETS][ASSOC];
    logic [AGE_W-1:0]  age_q   [SETS][ASSOC];
    logic [AGE_W-1:0]  age_d   [SETS][ASSOC];
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic [ADDR_W-1:0] fill_data_q, fill_data_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]  rd_idx, inv_idx, fill_idx, acc_idx;
    logic [TAG_W-1:0]  rd_tag, inv_tag, fill_tag;
    logic              rd_found, inv_found, vic_free, acc_en;
    logic [AGE_W-1:0]  rd_way, inv_way, vic_way, acc_way;

    assign rd_idx     = Address[IDX_W-1:0];
    assign rd_tag     = Address[ADDR_W-1:IDX_W];
    assign inv_idx    = Inv_Address[IDX_W-1:0];
    assign inv_tag    = Inv_Address[ADDR_W-1:IDX_W];
    assign fill_idx   = miss_addr_q[IDX_W-1:0];
    assign fill_tag   = miss_addr_q[ADDR_W-1:IDX_W];
    assign Miss_Count = miss_cnt_q;

    // Descending scan so the lowest matching/free way wins.
    always_comb begin
        rd_found  = 1'b0;
        rd_way    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        vic_free  = 1'b0;
        vic_way   = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (valid_q[rd_idx][w] && tag_q[rd_idx][w] == rd_tag) begin
                rd_found = 1'b1;
                rd_way   = AGE_W'(w);
            end
            if (valid_q[inv_idx][w] && tag_q[inv_idx][w] == inv_tag) begin
                inv_found = Inv_Valid;
                inv_way   = AGE_W'(w);
            end
            if (!valid_q[fill_idx][w]) begin
                vic_free = 1'b1;
                vic_way  = AGE_W'(w);
            end
        end
        if (!vic_free) begin
            for (int w = 0; w < ASSOC; w++) begin
                if (age_q[fill_idx][w] == AGE_W'(ASSOC - 1)) begin
                    vic_way = AGE_W'(w);
                end
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        tag_d            = tag_q;
        valid_d          = valid_q;
        data_d           = data_q;
        age_d            = age_q;
        miss_addr_d      = miss_addr_q;
        fill_data_d      = fill_data_q;
        miss_cnt_d       = miss_cnt_q;
        Data_Bus         = '0;
        CPU_stall        = 1'b0;
        Com_Bus_Req_proc = 1'b0;
        Address_Com      = '0;
        acc_en           = 1'b0;
        acc_idx          = rd_idx;
        acc_way          = rd_way;

        // Snoop first: a fill into the same way below overrides it.
        if (inv_found) begin
            valid_d[inv_idx][inv_way] = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (PrRd && rd_found) begin
                    Data_Bus = data_q[rd_idx][rd_way];
                    acc_en   = 1'b1;
                end else if (PrRd) begin
                    CPU_stall   = 1'b1;
                    miss_addr_d = Address;
                    state_d     = REQ;
                    if (miss_cnt_q != 16'hFFFF) begin
                        miss_cnt_d = miss_cnt_q + 16'd1;
                    end
                end
            end
            REQ: begin
                CPU_stall        = 1'b1;
                Com_Bus_Req_proc = 1'b1;
                if (Com_Bus_Gnt_proc) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                CPU_stall        = 1'b1;
                Com_Bus_Req_proc = 1'b1;
                Address_Com      = miss_addr_q;
                if (Data_in_Bus) begin
                    fill_data_d = Data_Bus_Com;
                    state_d     = FILL;
                end
            end
            FILL: begin
                CPU_stall                  = 1'b1;
                tag_d[fill_idx][vic_way]   = fill_tag;
                data_d[fill_idx][vic_way]  = fill_data_q;
                valid_d[fill_idx][vic_way] =
                    !(Inv_Valid && Inv_Address == miss_addr_q);
                acc_en                     = 1'b1;
                acc_idx                    = fill_idx;
                acc_way                    = vic_way;
                state_d                    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (acc_en) begin
            for (int w = 0; w < ASSOC; w++) begin
                if (AGE_W'(w) == acc_way) begin
                    age_d[acc_idx][w] = '0;
                end else if (age_q[acc_idx][w] < age_q[acc_idx][acc_way]) begin
                    age_d[acc_idx][w] = age_q[acc_idx][w] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            fill_data_q <= '0;
            miss_cnt_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < ASSOC; w++) begin
                    valid_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            fill_data_q <= fill_data_d;
            miss_cnt_q  <= miss_cnt_d;
            valid_q     <= valid_d;
            age_q       <= age_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_icache_unit_param.sv
// Bench for icache_unit_param: directed scenarios with literal expectations,
// then random traffic against a recency-list cache model.
module tb_icache_unit_param;
    localparam int AW = 32;
    localparam int S  = 4;
    localparam int A  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          PrRd;
    logic [AW-1:0] Address;
    logic [AW-1:0] Data_Bus;
    logic          CPU_stall;
    logic          Com_Bus_Req_proc;
    logic          Com_Bus_Gnt_proc;
    logic [AW-1:0] Address_Com;
    logic [AW-1:0] Data_Bus_Com;
    logic          Data_in_Bus;
    logic          Inv_Valid;
    logic [AW-1:0] Inv_Address;
    logic [15:0]   Miss_Count;

    always #5 clk = ~clk;

    icache_unit_param #(.ADDR_W(AW), .SETS(S), .ASSOC(A)) dut (
        .clk              (clk),
        .rst              (rst),
        .PrRd             (PrRd),
        .Address          (Address),
        .Data_Bus         (Data_Bus),
        .CPU_stall        (CPU_stall),
        .Com_Bus_Req_proc (Com_Bus_Req_proc),
        .Com_Bus_Gnt_proc (Com_Bus_Gnt_proc),
        .Address_Com      (Address_Com),
        .Data_Bus_Com     (Data_Bus_Com),
        .Data_in_Bus      (Data_in_Bus),
        .Inv_Valid        (Inv_Valid),
        .Inv_Address      (Inv_Address),
        .Miss_Count       (Miss_Count)
    );

    int checks = 0;
    int errors = 0;

    // Model: lines keyed by full address; m_rec front = most recently used.
    logic          m_val [S][A];
    logic [AW-1:0] m_tag [S][A];
    logic [AW-1:0] m_dat [S][A];
    int            m_rec [S][$];
    int            m_phase;
    logic [AW-1:0] m_miss, m_fill;
    int            m_cnt;

    logic [AW-1:0] e_data, e_acom;
    logic          e_stall, e_req;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int set_of(logic [AW-1:0] a);
        return int'(a[1:0]);
    endfunction

    function automatic bit lookup(input logic [AW-1:0] a, output int way);
        int s;
        s = set_of(a);
        way = 0;
        for (int w = 0; w < A; w++) begin
            if (m_val[s][w] && m_tag[s][w] == a) begin
                way = w;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void touch(int s, int w);
        for (int i = 0; i < m_rec[s].size(); i++) begin
            if (m_rec[s][i] == w) begin
                m_rec[s].delete(i);
                break;
            end
        end
        m_rec[s].push_front(w);
    endfunction

    function automatic int victim(int s);
        for (int w = 0; w < A; w++) begin
            if (!m_val[s][w]) return w;
        end
        return m_rec[s][A-1];
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < S; s++) begin
            m_rec[s].delete();
            for (int w = 0; w < A; w++) begin
                m_val[s][w] = 1'b0;
                m_rec[s].push_back(w);
            end
        end
        m_phase = 0;
        m_cnt   = 0;
    endfunction

    function automatic void model_outputs();
        int w;
        bit h;
        e_data  = '0;
        e_acom  = '0;
        e_stall = 1'b1;
        e_req   = 1'b0;
        case (m_phase)
            0: begin
                h       = PrRd && lookup(Address, w);
                e_stall = PrRd && !h;
                if (h) e_data = m_dat[set_of(Address)][w];
            end
            1: e_req = 1'b1;
            2: begin
                e_req  = 1'b1;
                e_acom = m_miss;
            end
            default: ;
        endcase
    endfunction

    function automatic void model_update();
        int  w, iw, s, v;
        bit  ih, do_fill;
        if (rst) begin
            model_reset();
            return;
        end
        ih      = Inv_Valid && lookup(Inv_Address, iw);
        do_fill = 1'b0;
        s       = 0;
        v       = 0;
        case (m_phase)
            0: if (PrRd) begin
                if (lookup(Address, w)) begin
                    touch(set_of(Address), w);
                end else begin
                    m_miss  = Address;
                    m_phase = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            1: if (Com_Bus_Gnt_proc) m_phase = 2;
            2: if (Data_in_Bus) begin
                m_fill  = Data_Bus_Com;
                m_phase = 3;
            end
            default: begin
                s       = set_of(m_miss);
                v       = victim(s);
                do_fill = 1'b1;
            end
        endcase
        if (ih) m_val[set_of(Inv_Address)][iw] = 1'b0;
        if (do_fill) begin
            m_val[s][v] = !(Inv_Valid && Inv_Address == m_miss);
            m_tag[s][v] = m_miss;
            m_dat[s][v] = m_fill;
            touch(s, v);
            m_phase = 0;
        end
    endfunction

    // Called at a falling edge with inputs already driven.
    task automatic step();
        #1;
        model_outputs();
        chk("data_bus", Data_Bus, e_data);
        chk("cpu_stall", 32'(CPU_stall), 32'(e_stall));
        chk("bus_req", 32'(Com_Bus_Req_proc), 32'(e_req));
        chk("address_com", Address_Com, e_acom);
        chk("miss_count", 32'(Miss_Count), 32'(m_cnt));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst              = 1'b0;
        PrRd             = 1'b0;
        Address          = '0;
        Com_Bus_Gnt_proc = 1'b0;
        Data_Bus_Com     = '0;
        Data_in_Bus      = 1'b0;
        Inv_Valid        = 1'b0;
        Inv_Address      = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic do_miss(logic [AW-1:0] a, logic [AW-1:0] d);
        PrRd    = 1'b1;
        Address = a;
        step();
        Com_Bus_Gnt_proc = 1'b1;
        step();
        Com_Bus_Gnt_proc = 1'b0;
        Data_in_Bus      = 1'b1;
        Data_Bus_Com     = d;
        step();
        Data_in_Bus = 1'b0;
        step();
    endtask

    task automatic read(logic [AW-1:0] a);
        PrRd    = 1'b1;
        Address = a;
        #1;
    endtask

    function automatic logic [AW-1:0] pool_addr();
        return (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Miss with no grant: request held, stall held, one miss counted.
        PrRd    = 1'b1;
        Address = 32'h10;
        step();
        step();
        step();
        chk("t1_req", 32'(Com_Bus_Req_proc), 32'd1);
        chk("t1_stall", 32'(CPU_stall), 32'd1);
        chk("t1_cnt", 32'(Miss_Count), 32'd1);
        Com_Bus_Gnt_proc = 1'b1;
        step();
        Com_Bus_Gnt_proc = 1'b0;
        chk("t2_acom", Address_Com, 32'h10);
        step();
        step();
        Data_in_Bus  = 1'b1;
        Data_Bus_Com = 32'hDEAD_BEEF;
        step();
        Data_in_Bus = 1'b0;
        chk("t2_fill_req", 32'(Com_Bus_Req_proc), 32'd0);
        step();
        chk("t2_data", Data_Bus, 32'hDEAD_BEEF);
        chk("t2_stall", 32'(CPU_stall), 32'd0);
        step();
        chk("t2_rehit", Data_Bus, 32'hDEAD_BEEF);
        chk("t2_cnt", 32'(Miss_Count), 32'd1);

        // LRU: tags 0..3 in set 0, touch tag 0, fifth fill evicts tag 1.
        reset_dut();
        for (int t = 0; t < 4; t++) do_miss(32'(t) << 2, 32'h100 + 32'(t));
        read(32'h0);
        step();
        do_miss(32'h10, 32'h104);
        read(32'h0);
        chk("lru_t0", Data_Bus, 32'h100);
        step();
        read(32'h8);
        chk("lru_t2", Data_Bus, 32'h102);
        step();
        read(32'hC);
        chk("lru_t3", Data_Bus, 32'h103);
        step();
        read(32'h10);
        chk("lru_t4", Data_Bus, 32'h104);
        step();
        read(32'h4);
        chk("lru_t1_miss", 32'(CPU_stall), 32'd1);
        step();

        // Snoop invalidation of a resident line.
        reset_dut();
        do_miss(32'h20, 32'hAA);
        PrRd        = 1'b0;
        Inv_Valid   = 1'b1;
        Inv_Address = 32'h20;
        step();
        Inv_Valid = 1'b0;
        read(32'h20);
        chk("inv_stall", 32'(CPU_stall), 32'd1);
        step();
        chk("inv_req", 32'(Com_Bus_Req_proc), 32'd1);
        chk("inv_cnt", 32'(Miss_Count), 32'd2);

        // Invalidation on the fill edge wins.
        reset_dut();
        PrRd    = 1'b1;
        Address = 32'h30;
        step();
        Com_Bus_Gnt_proc = 1'b1;
        step();
        Com_Bus_Gnt_proc = 1'b0;
        Data_in_Bus      = 1'b1;
        Data_Bus_Com     = 32'h55;
        step();
        Data_in_Bus = 1'b0;
        Inv_Valid   = 1'b1;
        Inv_Address = 32'h30;
        step();
        Inv_Valid = 1'b0;
        read(32'h30);
        chk("fillinv_stall", 32'(CPU_stall), 32'd1);
        step();
        chk("fillinv_cnt", 32'(Miss_Count), 32'd2);

        // Reset in the middle of a miss.
        reset_dut();
        do_miss(32'h40, 32'h77);
        read(32'h40);
        chk("rst_prehit", Data_Bus, 32'h77);
        step();
        read(32'h44);
        step();
        Com_Bus_Gnt_proc = 1'b1;
        step();
        Com_Bus_Gnt_proc = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        read(32'h40);
        chk("rst_req", 32'(Com_Bus_Req_proc), 32'd0);
        chk("rst_acom", Address_Com, 32'h0);
        chk("rst_cnt", 32'(Miss_Count), 32'd0);
        chk("rst_miss", 32'(CPU_stall), 32'd1);
        step();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (m_phase == 0 || $urandom_range(0, 3) == 0) begin
                PrRd    = ($urandom_range(0, 4) != 0);
                Address = pool_addr();
            end
            Com_Bus_Gnt_proc = 1'($urandom_range(0, 1));
            Data_in_Bus      = 1'($urandom_range(0, 1));
            Data_Bus_Com     = $urandom;
            Inv_Valid        = ($urandom_range(0, 9) == 0);
            Inv_Address      = pool_addr();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
